stream_arbiter_multiplexer: RTL and testbench
=============================================

# stream_arbiter_multiplexer

- Merges `N_STREAMS` valid/ready input streams into one output stream using round-robin arbitration with packet locking.
- Drives a single downstream consumer, such as a queue, card interface or host request port.
- Tags each output beat with `o_stream_id`, the index of its source stream, so a return-path demultiplexer can route responses back by `stream_select`/`dest`.
- Output is a single registered stage that sustains 1 beat/cycle.

## Interface
- `N_STREAMS`, default 2: number of input streams, ≥ 2.
- `DATA_TYPE`, default `logic[63:0]`: payload type, carried opaquely.
- `N_BITS`, default `$clog2(N_STREAMS)`: width of the stream index. Derived; never overridden.
- `clk` input, 1: the single clock. All logic is on the rising edge.
- `rst_n` input, 1: reset, synchronous, active-low. Pipelined through one register before use (reset resync).
- `i_data` input, `DATA_TYPE [N_STREAMS]`: per-stream payload.
- `i_valid` input, `[N_STREAMS]`: per-stream valid.
- `i_last` input, `[N_STREAMS]`: last beat of a packet. Tie to 1 for single-beat traffic.
- `i_ready` output, `[N_STREAMS]`: per-stream ready. At most one bit is high in any cycle.
- `o_data` output, `DATA_TYPE`: registered payload.
- `o_valid` output, 1: registered valid.
- `o_last` output, 1: registered last.
- `o_stream_id` output, `N_BITS`: index of the source stream of the current output beat.
- `o_ready` input, 1: downstream ready.

## Operation
- **Load enable:** `load = !o_valid || o_ready`. The output register accepts a new beat whenever it is empty or being drained.
- **State `ARB` (reset state):**
  - `grant` = first `k` with `i_valid[k]` high, scanning from `(last_id+1) mod N_STREAMS` upward with wrap.
  - `i_ready[grant] = load`; all other `i_ready` bits are 0. No valid input → all `i_ready` bits 0.
- **Transfer:** a transfer on stream `k` is `i_valid[k] && i_ready[k]`. On a transfer:
  - `o_data`, `o_last`, `o_stream_id` ← `i_data[k]`, `i_last[k]`, `k`.
  - `o_valid` ← 1.
  - If `i_last[k]`: `last_id` ← `k`, stay in `ARB`.
  - Else: `lock_id` ← `k`, go to `LOCKED`.
- **State `LOCKED`:**
  - Only `lock_id` is eligible: `i_ready[lock_id] = load`; all other `i_ready` bits are 0, even if `lock_id` is idle.
  - A transfer with `i_last` high → `last_id` ← `lock_id`, return to `ARB`.
- **No transfer while `load` is high:** `o_valid` ← 0.
- **`load` low:** output register holds; `o_data`/`o_last`/`o_stream_id` stay stable while `o_valid && !o_ready`.
- **Ready dependency:** `i_ready` depends combinationally on `i_valid` and `o_ready`. There is no combinational path from `i_data` to any output.
- **`last_id` update:** changes only at packet boundaries, so fairness is per packet, not per beat.

## Timing
- **Reset:** the registered reset goes low on the 1st edge with `rst_n` low sampled; state is cleared on the 2nd edge. Values after reset:
  - `o_valid` = 0, `o_last` = 0, `o_stream_id` = 0; `o_data` is not reset.
  - State = `ARB`; `last_id` = `N_STREAMS-1`, so stream 0 has first priority.
  - `i_ready` all 0 while reset is active.
- **Reset mid-packet:** the lock and any pending output beat are discarded. No beat is emitted after reset until a new transfer.
- **Latency:** input transfer at edge t → `o_valid` = 1 in the cycle after t.
- **Throughput:** with `o_ready` held high, one beat per cycle with no bubbles, including across grant switches.
- **Backpressure:** `o_ready` low with `o_valid` high → all `i_ready` = 0 in the same cycle.
- **Simultaneous drain and load:** when `o_ready` and a transfer occur in the same cycle, the old beat leaves and the new beat loads on the same edge.
- **Simultaneous valids:** the winner is strictly the first eligible index after `last_id`, wrapping modulo `N_STREAMS`. `last_id = N_STREAMS-1` wraps to index 0.

## Test plan
- **Round-robin, single-beat:** N=4, all `i_valid`=1, `i_last`=1, `o_ready`=1 → `o_stream_id` sequence 0,1,2,3,0,1…, one beat per cycle, first `o_valid` one cycle after the first transfer.
- **Packet lock:**
  - Stimulus: stream 1 sends a 3-beat packet (`i_last` on beat 3) while stream 0 is valid throughout.
  - Response: `o_stream_id` = 1,1,1 then 0; `i_ready[0]` = 0 during the lock.
  - Stimulus: stream 1 deasserts valid mid-packet.
  - Response: output stalls and stream 0 stays blocked.
- **Backpressure:** hold `o_ready`=0 for 5 cycles with `o_valid`=1 → `o_data`/`o_stream_id` stable, all `i_ready`=0; release → drains, and the next beat loads on the same edge.
- **Fairness skip:** only streams 0 and 2 valid, `last_id`=0 → next grant is 2, then 0; stream 1 never gets ready.
- **Reset mid-packet:** assert `rst_n`=0 during beat 2 of a locked packet → `o_valid`=0 two edges later and state is `ARB`; after release, stream 0 wins the first arbitration.
- **Idle:** no `i_valid` for 10 cycles with `o_ready`=1 → `o_valid`=0 and all `i_ready`=0.

Source files
------------

// File: rtl/stream_arbiter_multiplexer.sv
// Round-robin N:1 valid/ready stream merger with packet locking and a single
// registered output stage that tags every beat with its source stream index.
module stream_arbiter_multiplexer #(
    parameter int  N_STREAMS = 2,
    parameter type DATA_TYPE = logic [63:0],
    parameter int  N_BITS    = $clog2(N_STREAMS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  DATA_TYPE             i_data [N_STREAMS],
    input  logic [N_STREAMS-1:0] i_valid,
    input  logic [N_STREAMS-1:0] i_last,
    output logic [N_STREAMS-1:0] i_ready,
    output DATA_TYPE             o_data,
    output logic                 o_valid,
    output logic                 o_last,
    output logic [N_BITS-1:0]    o_stream_id,
    input  logic                 o_ready
);

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_r;
    logic                rst_sync_r;
    logic [N_BITS-1:0]   last_id_r;
    logic [N_BITS-1:0]   lock_id_r;

    logic                load_s;
    logic [N_BITS-1:0]   grant_s;
    logic [N_BITS-1:0]   sel_s;
    logic [N_STREAMS-1:0] rdy_s;
    logic                xfer_s;
    logic                sel_last_s;

    // First valid index strictly after 'last', wrapping modulo N_STREAMS.
    function automatic logic [N_BITS-1:0] rr_pick(
        input logic [N_STREAMS-1:0] valid,
        input logic [N_BITS-1:0]    last
    );
        logic [N_BITS-1:0] pick;
        logic              found;
        int                idx;
        pick  = last;
        found = 1'b0;
        for (int off = 1; off <= N_STREAMS; off++) begin
            idx = (int'(last) + off) % N_STREAMS;
            if (!found && valid[idx]) begin
                pick  = N_BITS'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Arbitration, ready generation and transfer detection.
    always_comb begin
        load_s     = !o_valid || o_ready;
        grant_s    = rr_pick(i_valid, last_id_r);
        rdy_s      = '0;
        sel_s      = grant_s;
        case (state_r)
            ARB:     sel_s = grant_s;
            LOCKED:  sel_s = lock_id_r;
            default: sel_s = grant_s;
        endcase
        // Both the raw and the resynchronised reset block handshakes so no
        // beat can slip in while reset is propagating.
        if (!rst_n || !rst_sync_r) begin
            rdy_s = '0;
        end else if (state_r == LOCKED) begin
            rdy_s[lock_id_r] = load_s;
        end else if (|i_valid) begin
            rdy_s[grant_s] = load_s;
        end else begin
            rdy_s = '0;
        end
        i_ready    = rdy_s;
        xfer_s     = |(i_valid & rdy_s);
        sel_last_s = i_last[sel_s];
    end

    // Reset resynchroniser, arbitration state and output control registers.
    always_ff @(posedge clk) begin
        rst_sync_r <= rst_n;
        if (!rst_sync_r) begin
            state_r     <= ARB;
            last_id_r   <= N_BITS'(N_STREAMS - 1);
            lock_id_r   <= '0;
            o_valid     <= 1'b0;
            o_last      <= 1'b0;
            o_stream_id <= '0;
        end else if (load_s) begin
            if (xfer_s) begin
                o_valid     <= 1'b1;
                o_last      <= sel_last_s;
                o_stream_id <= sel_s;
                case (state_r)
                    ARB: begin
                        if (sel_last_s) begin
                            last_id_r <= sel_s;
                        end else begin
                            lock_id_r <= sel_s;
                            state_r   <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (sel_last_s) begin
                            last_id_r <= lock_id_r;
                            state_r   <= ARB;
                        end else begin
                            state_r   <= LOCKED;
                        end
                    end
                    default: state_r <= ARB;
                endcase
            end else begin
                o_valid <= 1'b0;
            end
        end else begin
            o_valid <= o_valid;
        end
    end

    // Payload register; left unreset since o_valid qualifies it.
    always_ff @(posedge clk) begin
        if (load_s && xfer_s) begin
            o_data <= i_data[sel_s];
        end else begin
            o_data <= o_data;
        end
    end

endmodule

// File: tb/tb_stream_arbiter_multiplexer.sv
// Self-checking bench: vector table of per-cycle handshakes plus a scoreboard
// of expected output beats, and hand-written reset sequences.
module tb_stream_arbiter_multiplexer;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [63:0]       i_data [N];
    logic [N-1:0]      i_valid;
    logic [N-1:0]      i_last;
    logic [N-1:0]      i_ready;
    logic [63:0]       o_data;
    logic              o_valid;
    logic              o_last;
    logic [1:0]        o_stream_id;
    logic              o_ready;

    stream_arbiter_multiplexer #(.N_STREAMS(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .i_last      (i_last),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_last      (o_last),
        .o_stream_id (o_stream_id),
        .o_ready     (o_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic         ordy;
        logic [N-1:0] exp_rdy;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic        l;
        logic [1:0]  id;
    } beat_t;

    vec_t        vecs[$];
    beat_t       sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic        exp_valid = 1'b0;
    logic [31:0] cnt = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic [N-1:0] v, input logic [N-1:0] l, input logic o, input logic [N-1:0] e);
        vec_t t;
        t.v = v; t.l = l; t.ordy = o; t.exp_rdy = e;
        vecs.push_back(t);
    endtask

    // One cycle: drive at negedge, check outputs and ready, update the model.
    task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] l, input logic o, input logic [N-1:0] e);
        logic any;
        beat_t b;
        i_valid = v; i_last = l; o_ready = o;
        for (int k = 0; k < N; k++) i_data[k] = {32'(k), cnt};
        #1;
        chk("o_valid", 64'(o_valid), 64'(exp_valid));
        if (exp_valid) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                chk("o_data", o_data, sb[0].d);
                chk("o_stream_id", 64'(o_stream_id), 64'(sb[0].id));
                chk("o_last", 64'(o_last), 64'(sb[0].l));
                if (o) void'(sb.pop_front());
            end
        end
        chk("i_ready", 64'(i_ready), 64'(e));
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (v[k] && e[k]) begin
                b.d = i_data[k]; b.l = l[k]; b.id = 2'(k);
                sb.push_back(b);
                any = 1'b1;
            end
        end
        if (any) exp_valid = 1'b1;
        else if (!exp_valid || o) exp_valid = 1'b0;
        @(negedge clk);
        cnt++;
    endtask

    initial begin
        // Round-robin single-beat: 0,1,2,3,0,1
        add(4'b1111, 4'b1111, 1'b1, 4'b0001);
        add(4'b1111, 4'b1111, 1'b1, 4'b0010);
        add(4'b1111, 4'b1111, 1'b1, 4'b0100);
        add(4'b1111, 4'b1111, 1'b1, 4'b1000);
        add(4'b1111, 4'b1111, 1'b1, 4'b0001);
        add(4'b1111, 4'b1111, 1'b1, 4'b0010);
        // Idle 10 cycles
        for (int i = 0; i < 10; i++) add(4'b0000, 4'b1111, 1'b1, 4'b0000);
        // Move last_id to 0, then fairness skip between 0 and 2
        add(4'b0001, 4'b1111, 1'b1, 4'b0001);
        add(4'b0101, 4'b1111, 1'b1, 4'b0100);
        add(4'b0101, 4'b1111, 1'b1, 4'b0001);
        add(4'b0101, 4'b1111, 1'b1, 4'b0100);
        add(4'b0101, 4'b1111, 1'b1, 4'b0001);
        add(4'b0000, 4'b1111, 1'b1, 4'b0000);
        // Packet lock on stream 1 with a mid-packet valid gap; stream 0 blocked
        add(4'b0011, 4'b0001, 1'b1, 4'b0010);
        add(4'b0011, 4'b0001, 1'b1, 4'b0010);
        add(4'b0001, 4'b0001, 1'b1, 4'b0010);
        add(4'b0001, 4'b0001, 1'b1, 4'b0010);
        add(4'b0011, 4'b0011, 1'b1, 4'b0010);
        add(4'b0001, 4'b0001, 1'b1, 4'b0001);
        // Backpressure: 5 stalled cycles, then drain and load on one edge
        add(4'b0011, 4'b0011, 1'b1, 4'b0010);
        for (int i = 0; i < 5; i++) add(4'b0011, 4'b0011, 1'b0, 4'b0000);
        add(4'b0011, 4'b0011, 1'b1, 4'b0001);
        add(4'b0000, 4'b1111, 1'b1, 4'b0000);
        add(4'b0000, 4'b1111, 1'b1, 4'b0000);

        i_valid = '0; i_last = '0; o_ready = 1'b1;
        for (int k = 0; k < N; k++) i_data[k] = 64'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_last", 64'(o_last), 64'd0);
        chk("rst_o_stream_id", 64'(o_stream_id), 64'd0);
        i_valid = 4'b1111;
        #1;
        chk("rst_i_ready", 64'(i_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0000);

        for (int i = 0; i < vecs.size(); i++)
            cyc(vecs[i].v, vecs[i].l, vecs[i].ordy, vecs[i].exp_rdy);

        // Reset mid-packet: lock onto stream 2, reset during beat 2
        cyc(4'b0100, 4'b0000, 1'b1, 4'b0100);
        i_valid = 4'b0100; i_last = 4'b0000; o_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_i_ready0", 64'(i_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("midrst_i_ready1", 64'(i_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("midrst_o_valid", 64'(o_valid), 64'd0);
        @(negedge clk);
        sb.delete();
        exp_valid = 1'b0;
        rst_n = 1'b1;
        o_ready = 1'b1;
        cyc(4'b0101, 4'b0101, 1'b1, 4'b0000);
        cyc(4'b0101, 4'b0101, 1'b1, 4'b0001);
        cyc(4'b0101, 4'b0101, 1'b1, 4'b0100);
        cyc(4'b0000, 4'b1111, 1'b1, 4'b0000);
        cyc(4'b0000, 4'b1111, 1'b1, 4'b0000);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
